// File: rtl/update_writeback.sv
// DRAM-update stage: takes one {value, flag} word per vertex and queues a DRAM write for each
// flagged vertex. It also counts updates and reports per-pass convergence.
module update_writeback #(
  parameter int unsigned data_width = 64,
  parameter int unsigned addr_width = 32,
  parameter int unsigned idx_width  = 20,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [idx_width-1:0]  num_vertices_i,
  input  logic [addr_width-1:0] base_addr_i,
  input  logic                  valid_i,
  input  logic [data_width:0]   data_i,
  output logic                  ready_o,
  output logic                  mem_wr_valid_o,
  output logic [addr_width-1:0] mem_wr_addr_o,
  output logic [data_width-1:0] mem_wr_data_o,
  input  logic                  mem_wr_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [idx_width-1:0]  update_count_o,
  output logic                  changed_o
);

  localparam int unsigned Shift = $clog2(data_width / 8);
  localparam int unsigned PtrW  = $clog2(fifo_depth);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [idx_width-1:0]  num_q, num_d;
  logic [idx_width-1:0]  idx_q, idx_d;
  logic [idx_width-1:0]  cnt_q, cnt_d;
  logic [addr_width-1:0] base_q, base_d;
  logic                  changed_q, changed_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         occ_q, occ_d;
  logic [addr_width-1:0] last_addr_q;
  logic [data_width-1:0] last_data_q;
  logic [addr_width-1:0] fifo_addr_q [fifo_depth];
  logic [data_width-1:0] fifo_data_q [fifo_depth];

  logic                  fifo_empty, fifo_full, xfer, push, pop, last_vertex;
  logic [addr_width-1:0] wr_addr;

  assign fifo_empty  = (occ_q == '0);
  assign fifo_full   = (occ_q == (PtrW + 1)'(fifo_depth));
  assign ready_o     = (state_q == StRun) && !fifo_full;
  assign xfer        = valid_i && ready_o;
  assign push        = xfer && data_i[0];
  assign pop         = !fifo_empty && mem_wr_ready_i;
  assign last_vertex = (idx_q == num_q - idx_width'(1));
  // Address arithmetic wraps naturally at addr_width bits.
  assign wr_addr     = base_q + (addr_width'(idx_q) << Shift);

  assign mem_wr_valid_o = !fifo_empty;
  assign mem_wr_addr_o  = fifo_empty ? last_addr_q : fifo_addr_q[rd_ptr_q];
  assign mem_wr_data_o  = fifo_empty ? last_data_q : fifo_data_q[rd_ptr_q];
  assign busy_o         = (state_q == StRun) || (state_q == StDrain);
  assign done_o         = (state_q == StDone);
  assign update_count_o = cnt_q;
  assign changed_o      = changed_q;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    changed_d = changed_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d     = num_vertices_i;
          base_d    = base_addr_i;
          idx_d     = '0;
          cnt_d     = '0;
          changed_d = 1'b0;
          state_d   = (num_vertices_i != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (xfer) begin
          idx_d = idx_q + idx_width'(1);
          if (push && (cnt_q != '1)) cnt_d = cnt_q + idx_width'(1);
          if (last_vertex) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty || ((occ_q == (PtrW + 1)'(1)) && pop)) begin
          state_d   = StDone;
          changed_d = (cnt_q != '0);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + (PtrW + 1)'(1);
    else if (!push && pop) occ_d = occ_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      changed_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      changed_q <= changed_d;
      occ_q     <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PtrW'(1);
        // Keep the last popped entry visible once the queue runs empty.
        last_addr_q <= fifo_addr_q[rd_ptr_q];
        last_data_q <= fifo_data_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= data_i[data_width:1];
    end
  end

endmodule

// File: doc/update_writeback.md
Name: update_writeback

Overview:
- Downstream consumer of the compute stage's update output, i.e. the DRAM-update stage.
- Accepts one {vertex_value, update_flag} word per vertex, in vertex order, over valid/ready.
- For flagged vertices only, queues a DRAM write of the value at base_addr + vertex_index*bytes_per_word.
- Counts updates and reports per-pass convergence (no update issued) to the iteration controller.

Parameters:
- data_width, 64, vertex value width in bits; must be a multiple of 8 and a power of two.
- addr_width, 32, DRAM byte-address width.
- idx_width, 20, vertex index / count width.
- fifo_depth, 4, pending-write queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- start_i  in  1  one-cycle pulse that begins a pass; honoured only in IDLE.
- num_vertices_i  in  idx_width  vertices in the pass; sampled on accepted start_i.
- base_addr_i  in  addr_width  DRAM byte address of vertex 0; sampled on accepted start_i.
- valid_i  in  1  input word valid.
- data_i  in  data_width+1  bits [data_width:1] = vertex value, bit [0] = update flag.
- ready_o  out  1  block can accept data_i this cycle.
- mem_wr_valid_o  out  1  write request valid.
- mem_wr_addr_o  out  addr_width  write byte address.
- mem_wr_data_o  out  data_width  write data.
- mem_wr_ready_i  in  1  DRAM accepts the request this cycle.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse at pass end.
- update_count_o  out  idx_width  flagged vertices in the current or last pass.
- changed_o  out  1  update_count_o is non-zero; valid when done_o is high and held afterwards.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, FIFO empty, vertex index 0.
  - Outputs: ready_o 0, mem_wr_valid_o 0, mem_wr_addr_o 0, mem_wr_data_o 0, busy_o 0, done_o 0, update_count_o 0, changed_o 0.
  - Reset mid-pass discards all queued writes. A request being presented is dropped without completing.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i with num_vertices_i != 0. This also latches num_vertices_i and base_addr_i, and clears the index and update_count_o.
  - IDLE -> DONE on start_i with num_vertices_i == 0 (update_count_o cleared).
  - RUN -> DRAIN on the cycle the final vertex (index num_vertices-1) is accepted.
  - DRAIN -> DONE when the FIFO is empty, including the case where the last entry pops this cycle.
  - DONE -> IDLE unconditionally after 1 cycle; done_o is high only in DONE.
  - start_i outside IDLE is ignored.
- Input handshake:
  - ready_o = (state == RUN) && !fifo_full. It is registered-state only, with no combinational path from valid_i or mem_wr_ready_i.
  - Transfer occurs when valid_i && ready_o.
  - Every transfer increments the vertex index, whether or not the flag is set.
  - A flagged transfer pushes {addr, value} to the FIFO and increments update_count_o (saturating at all ones).
  - Unflagged transfers write nothing.
- Address: addr = base + (index << log2(data_width/8)), truncated to addr_width (wraps modulo 2^addr_width). Computed from the index before increment.
- Write port:
  - mem_wr_valid_o = FIFO non-empty; addr/data are the FIFO head.
  - Pop on mem_wr_valid_o && mem_wr_ready_i.
  - Once asserted, valid, addr and data are held stable until accepted.
  - Writes issue in acceptance order.
  - Minimum latency from input transfer to mem_wr_valid_o is 1 cycle (FIFO registered).
  - When the FIFO is empty, addr/data hold their last values.
- Simultaneous push and pop: allowed; occupancy unchanged.
  - When full, ready_o is 0 even if a pop occurs that cycle, so there is no bypass.
- changed_o is updated on entry to DONE as (update_count != 0) and held until the next accepted start_i, when it clears.
- update_count_o holds its value after DONE until the next accepted start_i.

Test Plan:
- Basic pass:
  - Stimulus: base 0x1000, N=4, inputs flags 1,0,1,0 with values 0xA,0xB,0xC,0xD, mem_wr_ready_i=1.
  - Response: exactly two writes, (0x1000,0xA) then (0x1010,0xC). update_count_o=2, changed_o=1, done_o pulses once, busy_o low after.
- Converged pass:
  - Stimulus: N=3, all flags 0.
  - Response: no mem_wr_valid_o ever. done_o pulses 1 cycle after the third accept. update_count_o=0, changed_o=0.
- Backpressure:
  - Stimulus: fifo_depth=4, N=8, all flagged, mem_wr_ready_i=0 until 20 cycles after start.
  - Response: ready_o drops after 4 accepts. Head addr/data stable while stalled. Once ready: 8 writes in order, state DRAIN until the last pop, then done_o.
- Zero vertices and illegal start:
  - Stimulus 1: start with N=0. Response: done_o the next cycle, no writes.
  - Stimulus 2: start_i pulsed during RUN. Response: ignored, count unaffected.
- Async reset mid-DRAIN:
  - Stimulus: assert rst_n low between clock edges with 3 writes queued.
  - Response: all outputs at reset values immediately; after release, no residual writes. A fresh pass (N=1, flag 1, base 0xFFFFFFF8, index 1 with N=2) shows the address wraps to 0x0.
- Random valid_i gaps with random mem_wr_ready_i, N=64, random flags:
  - Response: the write sequence matches the scoreboard (flagged indices, ascending).
  - update_count_o equals the flag popcount.
